// File: rtl/reg_bank_shadowed_pkg.sv
// Shared types and address decode for the shadowed register bank.
// Region helper keeps the address map in one place.
package reg_bank_pkg;

    typedef enum logic {
        IDLE,
        ARMED
    } commit_state_t;

    typedef enum logic [1:0] {
        REG_RO,
        REG_RW,
        REG_OOR
    } region_t;

    function automatic region_t decode_region(
        input int unsigned addr,
        input int unsigned ro_depth,
        input int unsigned rw_depth
    );
        if (addr < ro_depth) begin
            return REG_RO;
        end
        if (addr < ro_depth + rw_depth) begin
            return REG_RW;
        end
        return REG_OOR;
    endfunction

endpackage

// File: rtl/reg_bank_shadowed_if.sv
// Host register bus of the shadowed register bank.
// The host is the master, the bank is the slave.
interface reg_bank_shadowed_if #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_rvalid;
    logic                  mem_err;

    modport master (
        output mem_addr,
        output mem_data_in,
        output mem_we,
        output mem_re,
        input  mem_data_out,
        input  mem_rvalid,
        input  mem_err
    );

    modport slave (
        input  mem_addr,
        input  mem_data_in,
        input  mem_we,
        input  mem_re,
        output mem_data_out,
        output mem_rvalid,
        output mem_err
    );
endinterface

// File: rtl/reg_bank_shadowed_commit_fsm.sv
// Commit sequencer: decides when shadow words move to the active copy.
// Mode 0 waits for a frame boundary, mode 1 copies on the request itself.
module reg_bank_commit_fsm
    import reg_bank_pkg::*;
#(
    parameter int unsigned COMMIT_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic commit_req,
    input  logic frame_start,
    output logic copy_en,
    output logic commit_pending,
    output logic commit_done
);

    commit_state_t state_q;
    logic          pending_q;
    logic          done_q;

    // Copy strobe: acts on the same edge that sees the trigger
    always_comb begin
        copy_en = 1'b0;
        if (COMMIT_MODE == 0) begin
            copy_en = (state_q == ARMED) && frame_start;
        end else begin
            copy_en = (state_q == IDLE) && commit_req;
        end
    end

    // State register with registered pending/done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= copy_en;
            unique case (state_q)
                IDLE: begin
                    if (COMMIT_MODE == 0 && commit_req) begin
                        state_q   <= ARMED;
                        pending_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (frame_start) begin
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign commit_pending = pending_q;
    assign commit_done    = done_q;

endmodule

// File: rtl/reg_bank_shadowed.sv
// Register bank with status ROM, shadow RAM and atomically committed
// active copy feeding the gamma datapath.
module reg_bank_shadowed
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned RO_DEPTH     = 128,
    parameter int unsigned RW_DEPTH     = 128,
    parameter int unsigned RO_CH        = 4,
    parameter int unsigned DP_CH        = 4,
    parameter int unsigned COMMIT_MODE  = 0,
    parameter int unsigned RW_RESET_VAL = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    reg_bank_shadowed_if.slave          bus,
    input  logic [RO_CH*DATA_WIDTH-1:0] ro_in,
    input  logic                        commit_req,
    input  logic                        frame_start,
    output logic                        commit_pending,
    output logic                        commit_done,
    output logic [DP_CH*DATA_WIDTH-1:0] dp_out
);

    localparam int unsigned ADDR_W = $clog2(RO_DEPTH + RW_DEPTH);
    localparam int unsigned RW_IW  =
        (RW_DEPTH > 1) ? $clog2(RW_DEPTH) : 1;
    localparam logic [DATA_WIDTH-1:0] RST_W =
        DATA_WIDTH'(RW_RESET_VAL);

    if (RO_CH > RO_DEPTH) begin : g_bad_ro_ch
        $error("RO_CH must not exceed RO_DEPTH");
    end
    if (DP_CH > RW_DEPTH) begin : g_bad_dp_ch
        $error("DP_CH must not exceed RW_DEPTH");
    end
    if (RO_DEPTH < 1) begin : g_bad_ro_depth
        $error("RO_DEPTH must be at least 1");
    end
    if (RW_DEPTH < 1) begin : g_bad_rw_depth
        $error("RW_DEPTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0] ro_w     [RO_CH];
    logic [DATA_WIDTH-1:0] shadow_q [RW_DEPTH];
    logic [DATA_WIDTH-1:0] active_q [DP_CH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic                  err_q;
    region_t               region;
    logic [RW_IW-1:0]      rw_idx;
    logic                  wr_ok;
    logic                  wr_err;
    logic                  rd_err;
    logic                  copy_en;

    for (genvar c = 0; c < RO_CH; c++) begin : g_ro
        assign ro_w[c] = ro_in[c*DATA_WIDTH +: DATA_WIDTH];
    end

    assign region = decode_region(32'(bus.mem_addr), RO_DEPTH, RW_DEPTH);
    assign rw_idx = RW_IW'(bus.mem_addr - ADDR_W'(RO_DEPTH));
    assign wr_ok  = bus.mem_we && (region == REG_RW);
    assign wr_err = bus.mem_we && (region != REG_RW);
    assign rd_err = bus.mem_re && (region == REG_OOR);

    // Read mux: status channels, zero-filled ROM tail, shadow RAM
    always_comb begin
        rdata_d = '0;
        unique case (region)
            REG_RO: begin
                for (int c = 0; c < int'(RO_CH); c++) begin
                    if (bus.mem_addr == ADDR_W'(c)) begin
                        rdata_d = ro_w[c];
                    end
                end
            end
            REG_RW:  rdata_d = shadow_q[rw_idx];
            default: rdata_d = '0;
        endcase
    end

    // Shadow RAM: host writes land here only
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RW_DEPTH); i++) begin
                shadow_q[i] <= RST_W;
            end
        end else if (wr_ok) begin
            shadow_q[rw_idx] <= bus.mem_data_in;
        end
    end

    // Active copy: takes pre-write shadow values on the commit edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DP_CH); i++) begin
                active_q[i] <= RST_W;
            end
        end else if (copy_en) begin
            for (int i = 0; i < int'(DP_CH); i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // Read pipeline: one-cycle latency, data held between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= bus.mem_re;
            err_q    <= rd_err || wr_err;
            if (bus.mem_re) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign bus.mem_data_out = rdata_q;
    assign bus.mem_rvalid   = rvalid_q;
    assign bus.mem_err      = err_q;

    for (genvar d = 0; d < DP_CH; d++) begin : g_dp
        assign dp_out[d*DATA_WIDTH +: DATA_WIDTH] = active_q[d];
    end

    reg_bank_commit_fsm #(
        .COMMIT_MODE (COMMIT_MODE)
    ) u_commit (
        .clk            (clk),
        .rst            (rst),
        .commit_req     (commit_req),
        .frame_start    (frame_start),
        .copy_en        (copy_en),
        .commit_pending (commit_pending),
        .commit_done    (commit_done)
    );

endmodule

// File: tb/tb_reg_bank_shadowed.sv
// Bench for reg_bank_shadowed: frame-synchronised instance checked by a
// behavioural model every cycle, immediate-commit instance checked directly.
module tb_reg_bank_shadowed;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    reg_bank_shadowed_if #(.ADDR_W(8), .DATA_WIDTH(16)) bus0 ();
    reg_bank_shadowed_if #(.ADDR_W(8), .DATA_WIDTH(16)) bus1 ();

    logic [63:0] ro_in0 = '0;
    logic [63:0] ro_in1 = '0;
    logic        req0 = 0, fs0 = 0, req1 = 0, fs1 = 0;
    logic        pend0, done0, pend1, done1;
    logic [63:0] dp0, dp1;

    reg_bank_shadowed #(.RW_DEPTH(128), .COMMIT_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .ro_in(ro_in0),
        .commit_req(req0), .frame_start(fs0),
        .commit_pending(pend0), .commit_done(done0), .dp_out(dp0)
    );

    reg_bank_shadowed #(.RW_DEPTH(64), .COMMIT_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .ro_in(ro_in1),
        .commit_req(req1), .frame_start(fs1),
        .commit_pending(pend1), .commit_done(done1), .dp_out(dp1)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model of the mode-0 bank (256 addresses, 128 RW words)
    logic [15:0] m_sh [128];
    logic [15:0] m_act [4];
    logic [15:0] m_old [4];
    logic [15:0] m_rd;
    bit          m_armed, m_done, m_rv, m_err, m_live;
    int          m_a;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_sh[i]) m_sh[i] = '0;
            foreach (m_act[i]) m_act[i] = '0;
            m_armed = 0; m_done = 0; m_rv = 0; m_err = 0;
            m_rd = '0; m_live = 1;
        end else if (m_live) begin
            m_a = int'(bus0.mem_addr);
            for (int i = 0; i < 4; i++) m_old[i] = m_sh[i];
            m_rv  = bus0.mem_re;
            m_err = (bus0.mem_re && m_a >= 256) ||
                    (bus0.mem_we && (m_a < 128 || m_a >= 256));
            if (bus0.mem_re) begin
                if (m_a < 4)        m_rd = ro_in0[m_a*16 +: 16];
                else if (m_a < 128) m_rd = '0;
                else if (m_a < 256) m_rd = m_sh[m_a-128];
                else                m_rd = '0;
            end
            m_done = 0;
            if (m_armed && fs0) begin
                for (int i = 0; i < 4; i++) m_act[i] = m_old[i];
                m_armed = 0;
                m_done  = 1;
            end else if (!m_armed && req0) begin
                m_armed = 1;
            end
            if (bus0.mem_we && m_a >= 128 && m_a < 256)
                m_sh[m_a-128] = bus0.mem_data_in;
        end
    end

    // Per-cycle comparison of the mode-0 instance against the model
    always @(negedge clk) begin
        if (m_live && !rst) begin
            chk("m_rvalid", 64'(bus0.mem_rvalid), 64'(m_rv));
            chk("m_err", 64'(bus0.mem_err), 64'(m_err));
            chk("m_rdata", 64'(bus0.mem_data_out), 64'(m_rd));
            chk("m_pending", 64'(pend0), 64'(m_armed));
            chk("m_done", 64'(done0), 64'(m_done));
            chk("m_dp", dp0, {m_act[3], m_act[2], m_act[1], m_act[0]});
        end
    end

    bit saw_pend1 = 0;
    always @(negedge clk) begin
        if (!rst && pend1 === 1'b1) saw_pend1 = 1;
    end

    task automatic drv0(bit we, bit re, logic [7:0] a, logic [15:0] d,
                        bit rq, bit f);
        @(negedge clk);
        bus0.mem_we = we; bus0.mem_re = re;
        bus0.mem_addr = a; bus0.mem_data_in = d;
        req0 = rq; fs0 = f;
    endtask

    task automatic nop0();
        drv0(0, 0, 8'h00, 16'h0, 0, 0);
    endtask

    task automatic drv1(bit we, bit re, logic [7:0] a, logic [15:0] d,
                        bit rq, bit f);
        @(negedge clk);
        bus1.mem_we = we; bus1.mem_re = re;
        bus1.mem_addr = a; bus1.mem_data_in = d;
        req1 = rq; fs1 = f;
    endtask

    task automatic nop1();
        drv1(0, 0, 8'h00, 16'h0, 0, 0);
    endtask

    initial begin
        bus0.mem_we = 0; bus0.mem_re = 0;
        bus0.mem_addr = '0; bus0.mem_data_in = '0;
        bus1.mem_we = 0; bus1.mem_re = 0;
        bus1.mem_addr = '0; bus1.mem_data_in = '0;
        repeat (3) @(negedge clk);
        rst = 0;

        // 1: reset state and RAM reads
        chk("rst_dp0", dp0, 64'h0);
        chk("rst_pend0", 64'(pend0), 64'h0);
        chk("rst_rvalid0", 64'(bus0.mem_rvalid), 64'h0);
        chk("rst_dp1", dp1, 64'h0);
        drv0(0, 1, 8'h80, 16'h0, 0, 0); nop0();
        chk("rd80_rv", 64'(bus0.mem_rvalid), 64'h1);
        chk("rd80_data", 64'(bus0.mem_data_out), 64'h0);
        chk("rd80_err", 64'(bus0.mem_err), 64'h0);
        drv0(0, 1, 8'hFF, 16'h0, 0, 0); nop0();
        chk("rdFF_data", 64'(bus0.mem_data_out), 64'h0);
        chk("rdFF_err", 64'(bus0.mem_err), 64'h0);

        // 2: status region
        ro_in0 = 64'h4444_BEEF_2222_1111;
        drv0(0, 1, 8'h02, 16'h0, 0, 0); nop0();
        chk("rd02", 64'(bus0.mem_data_out), 64'hBEEF);
        drv0(0, 1, 8'h10, 16'h0, 0, 0); nop0();
        chk("rd10", 64'(bus0.mem_data_out), 64'h0);
        drv0(1, 0, 8'h02, 16'h1234, 0, 0); nop0();
        chk("wr02_err", 64'(bus0.mem_err), 64'h1);
        chk("wr02_rv", 64'(bus0.mem_rvalid), 64'h0);
        nop0();
        chk("err_pulse", 64'(bus0.mem_err), 64'h0);
        drv0(0, 1, 8'h02, 16'h0, 0, 0); nop0();
        chk("rd02_again", 64'(bus0.mem_data_out), 64'hBEEF);

        // 3: frame-synchronised commit
        drv0(1, 0, 8'h80, 16'h1234, 0, 0);
        drv0(1, 0, 8'h81, 16'h5678, 0, 0); nop0();
        chk("dp_before", dp0, 64'h0);
        drv0(0, 0, 8'h00, 16'h0, 1, 0); nop0();
        chk("armed", 64'(pend0), 64'h1);
        repeat (5) nop0();
        chk("still_armed", 64'(pend0), 64'h1);
        chk("dp_wait", dp0, 64'h0);
        drv0(0, 0, 8'h00, 16'h0, 0, 1); nop0();
        chk("dp_commit", dp0, 64'h0000_0000_5678_1234);
        chk("done_pulse", 64'(done0), 64'h1);
        chk("pend_clr", 64'(pend0), 64'h0);
        nop0();
        chk("done_end", 64'(done0), 64'h0);

        // 4: req+frame together only arms; copy takes pre-write value
        drv0(0, 0, 8'h00, 16'h0, 1, 1); nop0();
        chk("arm_only", 64'(pend0), 64'h1);
        chk("arm_no_done", 64'(done0), 64'h0);
        drv0(1, 0, 8'h80, 16'hAAAA, 0, 0);
        drv0(0, 0, 8'h00, 16'h0, 0, 1); nop0();
        chk("dp_aaaa", dp0, 64'h0000_0000_5678_AAAA);
        drv0(0, 0, 8'h00, 16'h0, 1, 0);
        drv0(1, 0, 8'h80, 16'hBBBB, 0, 1); nop0();
        chk("dp_prewrite", dp0, 64'h0000_0000_5678_AAAA);
        chk("done_prewrite", 64'(done0), 64'h1);
        drv0(0, 1, 8'h80, 16'h0, 0, 0); nop0();
        chk("shadow_bbbb", 64'(bus0.mem_data_out), 64'hBBBB);

        // 5: reset discards a pending commit
        drv0(0, 0, 8'h00, 16'h0, 1, 0); nop0();
        chk("arm5", 64'(pend0), 64'h1);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        chk("rst_pend", 64'(pend0), 64'h0);
        chk("rst_dp", dp0, 64'h0);
        drv0(0, 0, 8'h00, 16'h0, 0, 1); nop0();
        chk("no_done", 64'(done0), 64'h0);
        chk("no_pend", 64'(pend0), 64'h0);

        // 6: immediate-commit instance with 192-word map
        drv1(1, 0, 8'h81, 16'h5678, 0, 0);
        drv1(0, 1, 8'd200, 16'h0, 0, 0); nop1();
        chk("oor_data", 64'(bus1.mem_data_out), 64'h0);
        chk("oor_rv", 64'(bus1.mem_rvalid), 64'h1);
        chk("oor_err", 64'(bus1.mem_err), 64'h1);
        drv1(1, 1, 8'h81, 16'h0F0F, 0, 0); nop1();
        chk("rw_same_data", 64'(bus1.mem_data_out), 64'h5678);
        chk("rw_same_err", 64'(bus1.mem_err), 64'h0);
        drv1(0, 1, 8'h81, 16'h0, 0, 0); nop1();
        chk("rd81_new", 64'(bus1.mem_data_out), 64'h0F0F);
        drv1(0, 0, 8'h00, 16'h0, 0, 1); nop1();
        chk("fs_ignored", 64'(done1), 64'h0);
        chk("dp1_before", dp1, 64'h0);
        drv1(0, 0, 8'h00, 16'h0, 1, 0); nop1();
        chk("dp1_commit", dp1, 64'h0000_0000_0F0F_0000);
        chk("done1", 64'(done1), 64'h1);
        chk("pend1", 64'(pend1), 64'h0);
        nop1();
        chk("done1_end", 64'(done1), 64'h0);
        chk("pend1_never", 64'(saw_pend1), 64'h0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
